// File: rtl/fram_load_pkg.sv
// Shared types and CRC-32 constants for the FRAM region loaders.
package fram_load_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_RECV  = 2'd2,
    ST_CHECK = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_CRC     = 2'd1,
    ERR_LEN     = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_code_t;

  localparam logic [31:0] CRC_POLY   = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT   = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_XOROUT = 32'hFFFFFFFF;

endpackage

// File: rtl/crc32_d8.sv
// Combinational one-byte update of a reflected CRC-32 (LSB-first, poly 0xEDB88320).
module crc32_d8
  import fram_load_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  logic [31:0] w_c;

  always_comb begin
    w_c = crc_in ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      w_c = w_c[0] ? ((w_c >> 1) ^ CRC_POLY) : (w_c >> 1);
    end
    crc_out = w_c;
  end

endmodule

// File: rtl/fram_load_region.sv
// Loads one FRAM region into destination RAM, checking length, stall timeout and
// (with FRAM_LOAD_CRC_EN defined) the little-endian CRC-32 trailer.
module fram_load_region
  import fram_load_pkg::*;
#(
  parameter int                ADDR_W      = 16,
  parameter int                LEN_W       = 11,
  parameter logic [ADDR_W-1:0] SRC_ADDR    = '0,
  parameter int                LOAD_LEN    = 900,
  parameter logic [ADDR_W-1:0] DST_BASE    = 16'h0400,
  parameter int                TIMEOUT_CYC = 65535
) (
  input  logic              sys_clk,
  input  logic              glbl_rst,
  input  logic              load_en,
  output logic              load_busy,
  output logic              load_done,
  output logic              load_error,
  output logic [1:0]        load_err_code,
  output logic              rd_req,
  output logic [LEN_W-1:0]  rd_len,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_valid,
  input  logic              rd_last,
  input  logic [7:0]        rd_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic [31:0]       crc_rcvd,
  output logic [31:0]       crc_calc
);

  localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);

  state_t            r_state, w_state_nxt;
  err_code_t         r_err_code, w_fail_code;
  logic [LEN_W-1:0]  r_cnt;
  logic [IDLE_W-1:0] r_idle;
  logic [31:0]       r_crc_rcvd;
  logic              r_busy, r_done, r_error;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [7:0]        r_wr_data;
  logic              w_start, w_accept, w_payload, w_pass, w_fail, w_at_last, w_crc_ok;
  logic [31:0]       w_crc_calc;

`ifdef FRAM_LOAD_CRC_EN
  logic [31:0] r_crc;
  logic [31:0] w_crc_nxt;

  crc32_d8 u_crc (
    .crc_in  (r_crc),
    .data    (rd_data),
    .crc_out (w_crc_nxt)
  );

  assign w_crc_calc = r_crc ^ CRC_XOROUT;
  assign w_crc_ok   = (w_crc_calc == r_crc_rcvd);
`else
  assign w_crc_calc = '0;
  assign w_crc_ok   = 1'b1;
`endif

  assign w_at_last = (r_cnt == LEN_W'(LOAD_LEN - 1));
  assign w_payload = w_accept && (r_cnt < LEN_W'(LOAD_LEN - 4));

  always_ff @(posedge sys_clk or posedge glbl_rst) begin
    if (glbl_rst) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_accept    = 1'b0;
    w_pass      = 1'b0;
    w_fail      = 1'b0;
    w_fail_code = ERR_NONE;
    case (r_state)
      ST_IDLE: begin
        // A start landing on the done/error pulse cycle is dropped.
        if (load_en && !r_done && !r_error) begin
          w_start     = 1'b1;
          w_state_nxt = ST_REQ;
        end
      end
      ST_REQ: w_state_nxt = ST_RECV;
      ST_RECV: begin
        if (rd_valid) begin
          w_accept = 1'b1;
          if (rd_last && w_at_last) begin
            w_state_nxt = ST_CHECK;
          end else if (rd_last || w_at_last) begin
            w_fail      = 1'b1;
            w_fail_code = ERR_LEN;
            w_state_nxt = ST_IDLE;
          end
        end else if (r_idle == IDLE_W'(TIMEOUT_CYC - 1)) begin
          w_fail      = 1'b1;
          w_fail_code = ERR_TIMEOUT;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_CHECK: begin
        w_state_nxt = ST_IDLE;
        if (w_crc_ok) begin
          w_pass = 1'b1;
        end else begin
          w_fail      = 1'b1;
          w_fail_code = ERR_CRC;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge glbl_rst) begin
    if (glbl_rst) begin
      r_err_code <= ERR_NONE;
      r_cnt      <= '0;
      r_idle     <= '0;
      r_crc_rcvd <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
`ifdef FRAM_LOAD_CRC_EN
      r_crc      <= CRC_INIT;
`endif
    end else begin
      r_done    <= w_pass;
      r_error   <= w_fail;
      r_wr_en   <= w_payload;
      r_wr_addr <= w_payload ? DST_BASE + ADDR_W'(r_cnt) : '0;
      r_wr_data <= w_payload ? rd_data : 8'h00;

      if (w_start) begin
        r_err_code <= ERR_NONE;
        r_cnt      <= '0;
        r_crc_rcvd <= '0;
        r_busy     <= 1'b1;
`ifdef FRAM_LOAD_CRC_EN
        r_crc      <= CRC_INIT;
`endif
      end
      if (w_pass || w_fail) r_busy <= 1'b0;
      if (w_fail) r_err_code <= w_fail_code;

      if (r_state == ST_REQ) begin
        r_idle <= '0;
      end else if (r_state == ST_RECV) begin
        r_idle <= rd_valid ? '0 : r_idle + 1'b1;
      end

      if (w_accept) begin
        r_cnt <= r_cnt + 1'b1;
        if (w_payload) begin
`ifdef FRAM_LOAD_CRC_EN
          r_crc <= w_crc_nxt;
`endif
        end else begin
          r_crc_rcvd <= {rd_data, r_crc_rcvd[31:8]};
        end
      end
    end
  end

  assign rd_req        = (r_state == ST_REQ);
  assign rd_len        = rd_req ? LEN_W'(LOAD_LEN) : '0;
  assign rd_addr       = rd_req ? SRC_ADDR : '0;
  assign load_busy     = r_busy;
  assign load_done     = r_done;
  assign load_error    = r_error;
  assign load_err_code = r_err_code;
  assign wr_en         = r_wr_en;
  assign wr_addr       = r_wr_addr;
  assign wr_data       = r_wr_data;
  assign crc_rcvd      = r_crc_rcvd;
  assign crc_calc      = w_crc_calc;

endmodule

// File: tb/tb_fram_load_region.sv
// Directed bench for fram_load_region (13-byte region, 16-cycle timeout); expectations
// follow FRAM_LOAD_CRC_EN when it is defined for the build.
module tb_fram_load_region;

  logic        sys_clk = 1'b0;
  logic        glbl_rst = 1'b1;
  logic        load_en = 1'b0;
  logic        load_busy, load_done, load_error;
  logic [1:0]  load_err_code;
  logic        rd_req;
  logic [10:0] rd_len;
  logic [15:0] rd_addr;
  logic        rd_valid = 1'b0;
  logic        rd_last = 1'b0;
  logic [7:0]  rd_data = 8'h00;
  logic        wr_en;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic [31:0] crc_rcvd, crc_calc;

  int n_tests = 0;
  int n_fail  = 0;
  int n_wr    = 0;
  logic [15:0] wlog_addr[64];
  logic [7:0]  wlog_data[64];
  logic [7:0]  stream[13];

  fram_load_region #(
    .ADDR_W(16), .LEN_W(11), .SRC_ADDR(16'h0100), .LOAD_LEN(13),
    .DST_BASE(16'h0400), .TIMEOUT_CYC(16)
  ) dut (
    .sys_clk(sys_clk), .glbl_rst(glbl_rst), .load_en(load_en),
    .load_busy(load_busy), .load_done(load_done), .load_error(load_error),
    .load_err_code(load_err_code), .rd_req(rd_req), .rd_len(rd_len),
    .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_last(rd_last), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .crc_rcvd(crc_rcvd), .crc_calc(crc_calc)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock; outputs are sampled 1 ns after the edge and writes are logged.
  task automatic tick();
    @(posedge sys_clk);
    #1;
    if (wr_en === 1'b1 && n_wr < 64) begin
      wlog_addr[n_wr] = wr_addr;
      wlog_data[n_wr] = wr_data;
      n_wr++;
    end
  endtask

  task automatic start_load();
    n_wr    = 0;
    load_en = 1'b1;
    tick();
    load_en = 1'b0;
    tick();
  endtask

  task automatic send_bytes(input int n, input int last_idx);
    for (int i = 0; i < n; i++) begin
      rd_valid = 1'b1;
      rd_data  = stream[i];
      rd_last  = (i == last_idx);
      tick();
    end
    rd_valid = 1'b0;
    rd_last  = 1'b0;
    rd_data  = 8'h00;
  endtask

  task automatic set_stream(input logic [31:0] trailer);
    for (int i = 0; i < 9; i++) stream[i] = 8'h31 + 8'(i);
    for (int i = 0; i < 4; i++) stream[9 + i] = trailer[8*i +: 8];
  endtask

  task automatic check_payload_writes(input string tag, input int n);
    check({tag, " write count"}, n_wr, n);
    for (int i = 0; i < n; i++)
      check($sformatf("%s write %0d", tag, i), {wlog_addr[i], wlog_data[i]},
            {16'h0400 + 16'(i), 8'h31 + 8'(i)});
  endtask

  initial begin
    // Reset state
    #12;
    check("reset busy", load_busy, 0);
    check("reset rd_req", rd_req, 0);
    check("reset wr_en", wr_en, 0);
    check("reset err_code", load_err_code, 0);
    check("reset crc_calc", crc_calc, 0);
    check("reset crc_rcvd", crc_rcvd, 0);
    glbl_rst = 1'b0;
    tick();

    // A: good CRC trailer
    set_stream(32'hCBF43926);
    n_wr    = 0;
    load_en = 1'b1;
    tick();
    load_en = 1'b0;
    check("A rd_req", rd_req, 1);
    check("A rd_len", rd_len, 13);
    check("A rd_addr", rd_addr, 16'h0100);
    check("A busy", load_busy, 1);
    tick();
    check("A rd_req one cycle", {rd_req, rd_len, rd_addr}, 0);
    rd_valid = 1'b1; rd_data = stream[0];
    tick();
    check("A first write latency", {wr_en, wr_addr, wr_data}, {1'b1, 16'h0400, 8'h31});
    load_en = 1'b1;  // start while busy must be ignored
    for (int i = 1; i < 13; i++) begin
      rd_data = stream[i];
      rd_last = (i == 12);
      tick();
      load_en = 1'b0;
      if (i == 1) check("A start ignored while busy", rd_req, 0);
    end
    rd_valid = 1'b0; rd_last = 1'b0;
    check("A no pulse in CHECK", {load_done, load_error, load_busy}, 3'b001);
    tick();
    check("A done pulse", {load_done, load_error, load_busy}, 3'b100);
    check("A err_code", load_err_code, 0);
    check("A crc_rcvd", crc_rcvd, 32'hCBF43926);
`ifdef FRAM_LOAD_CRC_EN
    check("A crc_calc", crc_calc, 32'hCBF43926);
`else
    check("A crc_calc", crc_calc, 0);
`endif
    load_en = 1'b1;  // coincident with the pulse: ignored
    tick();
    load_en = 1'b0;
    check("A pulse one cycle", {load_done, load_error}, 0);
    check("A start on pulse ignored", {rd_req, load_busy}, 0);
    check_payload_writes("A", 9);

    // B: wrong trailer
    set_stream(32'h0);
    start_load();
    send_bytes(13, 12);
    tick();
`ifdef FRAM_LOAD_CRC_EN
    check("B crc error pulse", {load_done, load_error}, 2'b01);
    check("B err_code", load_err_code, 1);
    check("B crc_calc", crc_calc, 32'hCBF43926);
`else
    check("B done without CRC", {load_done, load_error}, 2'b10);
    check("B err_code", load_err_code, 0);
    check("B crc_calc", crc_calc, 0);
`endif
    check("B crc_rcvd", crc_rcvd, 0);
    check_payload_writes("B", 9);

    // C: early rd_last on byte 10
    set_stream(32'hCBF43926);
    tick();
    start_load();
    send_bytes(11, 10);
    check("C length error pulse", {load_done, load_error, load_busy}, 3'b010);
    check("C err_code", load_err_code, 2);
    rd_valid = 1'b1; rd_data = 8'hAA;
    tick();
    tick();
    rd_valid = 1'b0;
    tick();
    check("C late bytes ignored", {load_busy, load_done, load_error}, 0);
    check_payload_writes("C", 9);

    // D: stall after 5 bytes
    start_load();
    send_bytes(5, -1);
    begin
      int k;
      k = 0;
      while (load_error !== 1'b1 && k < 40) begin
        tick();
        k++;
      end
      check("D timeout idle cycles", k, 16);
    end
    check("D err_code", load_err_code, 3);
    check_payload_writes("D", 5);

    // E: reset mid-stream, then a clean load
    tick();
    start_load();
    send_bytes(4, -1);
    check("E write before reset", wr_en, 1);
    #2 glbl_rst = 1'b1;
    #1;
    check("E outputs cleared", {load_busy, load_done, load_error, rd_req, wr_en, wr_data, wr_addr}, 0);
    check("E crc regs cleared", {crc_rcvd, crc_calc}, 0);
    tick();
    glbl_rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("E no pulse after reset", {load_done, load_error, load_busy}, 0);
    end
    start_load();
    send_bytes(13, 12);
    tick();
    check("E clean load done", {load_done, load_error, load_err_code}, 4'b1000);
    check_payload_writes("E", 9);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
